// File: rtl/ibex_ccu_ctrl.sv
// Sequencing controller between EX and the custom compute unit: issues one latched
// command, waits for its response, and masks flushes, timeouts and orphaned responses.
module ibex_ccu_ctrl #(
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned FuncIdWidth   = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [FuncIdWidth-1:0] req_function_id_i,
  input  logic [31:0]            req_operand_a_i,
  input  logic [31:0]            req_operand_b_i,
  input  logic                   flush_i,
  input  logic                   ready_id_i,
  output logic                   ccu_cmd_valid_o,
  input  logic                   ccu_cmd_ready_i,
  output logic [FuncIdWidth-1:0] ccu_cmd_function_id_o,
  output logic [31:0]            ccu_cmd_inputs_0_o,
  output logic [31:0]            ccu_cmd_inputs_1_o,
  input  logic                   ccu_rsp_valid_i,
  input  logic [31:0]            ccu_rsp_outputs_0_i,
  output logic                   ccu_rsp_ready_o,
  output logic [31:0]            result_o,
  output logic                   valid_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   stale_q, stale_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [31:0]            result_q, result_d;
  logic [FuncIdWidth-1:0] func_id_q;
  logic [31:0]            op_a_q, op_b_q;
  logic                   load_cmd;
  logic                   cmd_hs;
  logic                   timeout_hit;
  logic                   illegal_rsp;

  assign ccu_cmd_valid_o       = (state_q == ISSUE) && !stale_q;
  assign cmd_hs                = ccu_cmd_valid_o && ccu_cmd_ready_i;
  assign timeout_hit           = TimeoutEn && (cnt_q == CntLast);
  assign ccu_cmd_function_id_o = func_id_q;
  assign ccu_cmd_inputs_0_o    = op_a_q;
  assign ccu_cmd_inputs_1_o    = op_b_q;
  assign ccu_rsp_ready_o       = 1'b1;
  assign result_o              = result_q;
  assign err_o                 = err_q;
  assign busy_o                = (state_q != IDLE);
  assign valid_o               = (state_q == DONE) && !flush_i;

  always_comb begin
    state_d  = state_q;
    stale_d  = stale_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    load_cmd = 1'b0;

    // A response arriving while stale always belongs to the aborted command.
    if (stale_q && ccu_rsp_valid_i) stale_d = 1'b0;
    if ((state_q == ISSUE || state_q == WAIT) && cnt_q != CntMax) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          load_cmd = 1'b1;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (flush_i) begin
          state_d = IDLE;
          if (cmd_hs) stale_d = 1'b1;
        end else if (cmd_hs && ccu_rsp_valid_i) begin
          result_d = ccu_rsp_outputs_0_i;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (cmd_hs && !timeout_hit) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
          if (cmd_hs) stale_d = 1'b1;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
          stale_d = !ccu_rsp_valid_i;
        end else if (ccu_rsp_valid_i) begin
          result_d = ccu_rsp_outputs_0_i;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          stale_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (flush_i || ready_id_i) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      stale_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      stale_q  <= stale_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      func_id_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else if (load_cmd) begin
      func_id_q <= req_function_id_i;
      op_a_q    <= req_operand_a_i;
      op_b_q    <= req_operand_b_i;
    end
  end

  // Only WAIT, or ISSUE completing in the same cycle as the handshake, may see a live response.
  assign illegal_rsp = ccu_rsp_valid_i && !stale_q &&
                       !((state_q == WAIT) || (state_q == ISSUE && cmd_hs));

  rsp_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !illegal_rsp);

endmodule

// File: tb/tb_ibex_ccu_ctrl.sv
// Directed bench for ibex_ccu_ctrl: stimulus pushes expected results into a scoreboard
// that a separate monitor drains whenever the ID stage consumes a result.
module tb_ibex_ccu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [9:0]  req_function_id_i = '0;
  logic [31:0] req_operand_a_i = '0;
  logic [31:0] req_operand_b_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_id_i = 1'b0;
  logic        ccu_cmd_valid_o;
  logic        ccu_cmd_ready_i = 1'b0;
  logic [9:0]  ccu_cmd_function_id_o;
  logic [31:0] ccu_cmd_inputs_0_o;
  logic [31:0] ccu_cmd_inputs_1_o;
  logic        ccu_rsp_valid_i = 1'b0;
  logic [31:0] ccu_rsp_outputs_0_i = '0;
  logic        ccu_rsp_ready_o;
  logic [31:0] result_o;
  logic        valid_o;
  logic        err_o;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   num_checks = 0;
  int   num_fails  = 0;

  ibex_ccu_ctrl #(
    .TimeoutCycles(8),
    .FuncIdWidth  (10)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_i                (req_i),
    .req_function_id_i    (req_function_id_i),
    .req_operand_a_i      (req_operand_a_i),
    .req_operand_b_i      (req_operand_b_i),
    .flush_i              (flush_i),
    .ready_id_i           (ready_id_i),
    .ccu_cmd_valid_o      (ccu_cmd_valid_o),
    .ccu_cmd_ready_i      (ccu_cmd_ready_i),
    .ccu_cmd_function_id_o(ccu_cmd_function_id_o),
    .ccu_cmd_inputs_0_o   (ccu_cmd_inputs_0_o),
    .ccu_cmd_inputs_1_o   (ccu_cmd_inputs_1_o),
    .ccu_rsp_valid_i      (ccu_rsp_valid_i),
    .ccu_rsp_outputs_0_i  (ccu_rsp_outputs_0_i),
    .ccu_rsp_ready_o      (ccu_rsp_ready_o),
    .result_o             (result_o),
    .valid_o              (valid_o),
    .err_o                (err_o),
    .busy_o               (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [9:0] id, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic rid,
                               input logic crdy, input logic rv, input logic [31:0] rd);
    req_i               = r;
    req_function_id_i   = id;
    req_operand_a_i     = a;
    req_operand_b_i     = b;
    flush_i             = fl;
    ready_id_i          = rid;
    ccu_cmd_ready_i     = crdy;
    ccu_rsp_valid_i     = rv;
    ccu_rsp_outputs_0_i = rd;
  endtask

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample;
    @(negedge clk_i);
  endtask

  task automatic expect_result(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Monitor: every result the ID stage consumes must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_id_i && !flush_i) begin
      if (sb.size() == 0) begin
        num_checks++;
        num_fails++;
        $display("[TB] FAIL sb_unexpected: got result 0x%08h err %0b, expected no result",
                 result_o, err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_result", result_o, e.data);
        checkOutput("sb_err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    next_cycle;
    next_cycle;
    sample;
    checkOutput("rst_cmd_valid", {31'b0, ccu_cmd_valid_o}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("rst_err", {31'b0, err_o}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_rsp_ready", {31'b0, ccu_rsp_ready_o}, 32'd1);
    checkOutput("rst_func_id", {22'b0, ccu_cmd_function_id_o}, 32'd0);
    checkOutput("rst_in0", ccu_cmd_inputs_0_o, 32'd0);
    checkOutput("rst_in1", ccu_cmd_inputs_1_o, 32'd0);
    next_cycle;
    rst_ni = 1'b1;

    // Test 1: combinational CCU, minimum latency
    applyStimulus(1, 10'h005, 32'h1111_0000, 32'h2222_0000, 0, 1, 1, 0, 0);
    sample;
    checkOutput("t1_idle_busy", {31'b0, busy_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 1, 1, 32'h1234_5678);
    expect_result(32'h1234_5678, 1'b0);
    sample;
    checkOutput("t1_cmd_valid_c1", {31'b0, ccu_cmd_valid_o}, 32'd1);
    checkOutput("t1_func_id", {22'b0, ccu_cmd_function_id_o}, 32'h005);
    checkOutput("t1_in0", ccu_cmd_inputs_0_o, 32'h1111_0000);
    checkOutput("t1_in1", ccu_cmd_inputs_1_o, 32'h2222_0000);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    sample;
    checkOutput("t1_valid_c2", {31'b0, valid_o}, 32'd1);
    next_cycle;
    sample;
    checkOutput("t1_idle_c3", {31'b0, busy_o}, 32'd0);
    checkOutput("t1_valid_c3", {31'b0, valid_o}, 32'd0);
    next_cycle;

    // Test 2: delayed cmd_ready and response; payload must stay latched
    applyStimulus(1, 10'h02A, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 0, 0, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h3FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ccu_cmd_ready_i = 1'b1;
      sample;
      checkOutput("t2_cmd_valid", {31'b0, ccu_cmd_valid_o}, 32'd1);
      checkOutput("t2_func_id", {22'b0, ccu_cmd_function_id_o}, 32'h02A);
      checkOutput("t2_in0", ccu_cmd_inputs_0_o, 32'hA5A5_A5A5);
      checkOutput("t2_in1", ccu_cmd_inputs_1_o, 32'h5A5A_5A5A);
      next_cycle;
    end
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample;
      checkOutput("t2_wait_cmd_valid", {31'b0, ccu_cmd_valid_o}, 32'd0);
      checkOutput("t2_wait_valid", {31'b0, valid_o}, 32'd0);
      next_cycle;
    end
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    expect_result(32'hCAFE_F00D, 1'b0);
    sample;
    checkOutput("t2_valid_c8", {31'b0, valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    sample;
    checkOutput("t2_valid_c9", {31'b0, valid_o}, 32'd1);
    checkOutput("t2_err_c9", {31'b0, err_o}, 32'd0);
    checkOutput("t2_result_c9", result_o, 32'hCAFE_F00D);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    sample;
    checkOutput("t2_idle", {31'b0, busy_o}, 32'd0);
    next_cycle;

    // Test 3: timeout after acceptance, then a stale response blocks the next command
    applyStimulus(1, 10'h003, 32'h1, 32'h2, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 0, 0);
    sample;
    checkOutput("t3_cmd_valid", {31'b0, ccu_cmd_valid_o}, 32'd1);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    expect_result(32'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      sample;
      checkOutput("t3_no_early_valid", {31'b0, valid_o}, 32'd0);
      checkOutput("t3_busy", {31'b0, busy_o}, 32'd1);
      next_cycle;
    end
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    sample;
    checkOutput("t3_timeout_valid", {31'b0, valid_o}, 32'd1);
    checkOutput("t3_timeout_err", {31'b0, err_o}, 32'd1);
    checkOutput("t3_timeout_result", result_o, 32'd0);
    next_cycle;
    applyStimulus(1, 10'h004, 32'h44, 32'h55, 0, 0, 1, 0, 0);
    sample;
    checkOutput("t3_idle_err_clr", {31'b0, err_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 0, 0);
    sample;
    checkOutput("t3_stale_hold", {31'b0, ccu_cmd_valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'h0000_DEAD);
    sample;
    checkOutput("t3_stale_hold2", {31'b0, ccu_cmd_valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'h0000_BEEF);
    expect_result(32'h0000_BEEF, 1'b0);
    sample;
    checkOutput("t3_reissue", {31'b0, ccu_cmd_valid_o}, 32'd1);
    checkOutput("t3_func_id", {22'b0, ccu_cmd_function_id_o}, 32'h004);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    next_cycle;

    // Test 4: flush in WAIT, late response dropped, next command correct
    applyStimulus(1, 10'h007, 32'h7, 32'h7, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 1, 0, 0, 0, 0);
    sample;
    checkOutput("t4_wait_busy", {31'b0, busy_o}, 32'd1);
    next_cycle;
    applyStimulus(1, 10'h008, 32'h80, 32'h81, 0, 0, 0, 0, 0);
    sample;
    checkOutput("t4_flushed_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("t4_flushed_valid", {31'b0, valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'hBAD0_0001);
    sample;
    checkOutput("t4_stale_hold", {31'b0, ccu_cmd_valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'h1111_2222);
    expect_result(32'h1111_2222, 1'b0);
    sample;
    checkOutput("t4_reissue", {31'b0, ccu_cmd_valid_o}, 32'd1);
    checkOutput("t4_in0", ccu_cmd_inputs_0_o, 32'h80);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    next_cycle;

    // Test 5: flush coincides with the response in WAIT; nothing left stale
    applyStimulus(1, 10'h009, 32'h9, 32'h9, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 1, 0, 0, 1, 32'h5555_5555);
    sample;
    checkOutput("t5_flush_valid", {31'b0, valid_o}, 32'd0);
    next_cycle;
    applyStimulus(1, 10'h00A, 32'hA0, 32'hA1, 0, 0, 1, 0, 0);
    sample;
    checkOutput("t5_idle", {31'b0, busy_o}, 32'd0);
    checkOutput("t5_no_valid", {31'b0, valid_o}, 32'd0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'h6666_6666);
    expect_result(32'h6666_6666, 1'b0);
    sample;
    checkOutput("t5_not_stale", {31'b0, ccu_cmd_valid_o}, 32'd1);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 1, 0, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    next_cycle;

    // Test 6: asynchronous reset while holding a result in DONE
    applyStimulus(1, 10'h00B, 32'hB0, 32'hB1, 0, 0, 1, 0, 0);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 1, 1, 32'h7777_7777);
    next_cycle;
    applyStimulus(0, 10'h000, 0, 0, 0, 0, 0, 0, 0);
    sample;
    checkOutput("t6_done_valid", {31'b0, valid_o}, 32'd1);
    checkOutput("t6_done_result", result_o, 32'h7777_7777);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("t6_rst_result", result_o, 32'd0);
    checkOutput("t6_rst_err", {31'b0, err_o}, 32'd0);
    next_cycle;
    rst_ni = 1'b1;
    sample;
    checkOutput("t6_post_rst_busy", {31'b0, busy_o}, 32'd0);
    next_cycle;

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
